mips_cpu_wb_arbiter: RTL and testbench
======================================

// Module: mips_cpu_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between ALU writeback and load-return writeback.
//  Keeps a per-register pending-load scoreboard so decode can stall on RAW hazards against loads still in flight.
//  Sits between execute/memory stages and the register file.
//  Drives the register file's write, wrAddr and wrData inputs from registers.
// PARAMETERS
//  MAX_WAIT  4  cycles ALU may be refused while mem wins before ALU gets forced priority (1..15)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  alu_valid      in   1   ALU writeback request
//  alu_ready      out  1   ALU request accepted this cycle (comb)
//  alu_addr       in   5   ALU destination register
//  alu_data       in   32  ALU result
//  mem_valid      in   1   load-return writeback request
//  mem_ready      out  1   load request accepted this cycle (comb)
//  mem_addr       in   5   load destination register
//  mem_data       in   32  load data
//  load_issue     in   1   load issued to memory; mark load_addr pending
//  load_addr      in   5   destination of issued load
//  chk_addr_a     in   5   decode source A
//  chk_addr_b     in   5   decode source B
//  hazard         out  1   chk_addr_a or chk_addr_b pending (comb)
//  rf_write       out  1   register-file write enable (registered)
//  rf_wrAddr      out  5   register-file write address (registered)
//  rf_wrData      out  32  register-file write data (registered)
//  sb_err         out  1   sticky; load issued to an already-pending register
// BEHAVIOUR
//  Reset: rf_write=0, rf_wrAddr=0, rf_wrData=0, pending[31:0]=0, wait_cnt=0, sb_err=0.
//  Grant (comb): at most one of alu_ready/mem_ready high per cycle; both 0 during reset.
//  - If only one requester is valid, it is granted.
//  - If both are valid, mem is granted unless wait_cnt==MAX_WAIT; in that case ALU is granted.
//  wait_cnt (4b): +1 when alu_valid and ALU is not granted.
//  - It saturates at MAX_WAIT and clears to 0 on any ALU grant or when alu_valid=0.
//  Write-out, latency 1: the cycle after a grant, rf_write=1 and rf_wrAddr/rf_wrData = granted addr/data.
//  - With no grant, rf_write=0 and addr/data hold their previous values.
//  - A granted write to addr 0 is accepted (ready=1), but the next-cycle rf_write=0.
//  Scoreboard: pending[load_addr] is set on load_issue, except when load_addr==0.
//  - pending[mem_addr] is cleared when mem is granted.
//  - pending[0] is always 0.
//  - If load_issue and the mem grant target the same address in one cycle, set wins: the bit stays 1.
//  - load_issue to a register that is already pending (and not cleared that cycle) sets sb_err=1.
//    sb_err clears only on reset.
//  hazard = pending[chk_addr_a] | pending[chk_addr_b], using current-cycle bits.
//  - No bypass: a register cleared this cycle still reads hazard=1 until the next edge.
//  ALU writes do not touch the scoreboard.
//  Reset mid-operation: in-flight grants are dropped; rf_write=0 in the cycle after reset is sampled.
//  Requesters hold valid/addr/data until ready (standard valid/ready); the arbiter does not buffer.
// TESTING
//  1. Only alu_valid with addr=5, data=0xDEADBEEF -> alu_ready same cycle.
//     Next cycle: rf_write=1, rf_wrAddr=5, rf_wrData=0xDEADBEEF.
//  2. alu_valid and mem_valid both held high, MAX_WAIT=4 -> mem granted in cycles 0-3.
//     ALU granted in cycle 4; wait_cnt returns to 0.
//  3. load_issue addr=8, then chk_addr_a=8 -> hazard=1.
//     mem grant for addr 8 -> hazard=0 one cycle after the grant edge.
//  4. load_issue addr=0 -> pending stays 0, hazard=0 for chk 0.
//     ALU write to addr 0 -> alu_ready=1, rf_write stays 0.
//  5. load_issue addr=3 twice with no return -> sb_err=1, which persists until reset.
//     load_issue addr=3 in the same cycle as the mem grant for addr 3 -> pending[3]=1, sb_err=0.
//  6. Assert reset while a grant is active and 4 registers are pending.
//     Next cycle: rf_write=0, hazard=0 for all addresses, sb_err=0, wait_cnt=0.

Source files
------------

// File: rtl/mips_cpu_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_wb_arbiter_if
// Purpose  : Writeback request, load-scoreboard and register-file write bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_cpu_wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        load_issue;
    logic [4:0]  load_addr;
    logic [4:0]  chk_addr_a;
    logic [4:0]  chk_addr_b;
    logic        hazard;
    logic        rf_write;
    logic [4:0]  rf_wrAddr;
    logic [31:0] rf_wrData;
    logic        sb_err;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  load_issue, load_addr, chk_addr_a, chk_addr_b,
        output alu_ready, mem_ready, hazard,
        output rf_write, rf_wrAddr, rf_wrData, sb_err
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output load_issue, load_addr, chk_addr_a, chk_addr_b,
        input  alu_ready, mem_ready, hazard,
        input  rf_write, rf_wrAddr, rf_wrData, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_wb_arbiter
// Purpose  : Arbitrates ALU vs load-return writeback onto the single register
//            file write port and tracks per-register pending loads.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_cpu_wb_arbiter_if.slave    bus
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    logic        w_alu_gnt;
    logic        w_mem_gnt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_nxt;

    logic        r_rf_write;
    logic [4:0]  r_rf_wraddr;
    logic [31:0] r_rf_wrdata;
    logic        w_rf_write_nxt;
    logic [4:0]  w_rf_wraddr_nxt;
    logic [31:0] w_rf_wrdata_nxt;

    logic [31:0] r_pending;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_pending_nxt;
    logic        r_sb_err;
    logic        w_sb_err_nxt;

    // Loads win ties so the pipeline drains, unless the ALU has starved long enough.
    always_comb begin
        w_alu_gnt = 1'b0;
        w_mem_gnt = 1'b0;
        if (!reset) begin
            if (bus.alu_valid && bus.mem_valid) begin
                if (r_wait_cnt == c_max_wait) begin
                    w_alu_gnt = 1'b1;
                end else begin
                    w_mem_gnt = 1'b1;
                end
            end else if (bus.alu_valid) begin
                w_alu_gnt = 1'b1;
            end else if (bus.mem_valid) begin
                w_mem_gnt = 1'b1;
            end
        end
    end

    assign bus.alu_ready = w_alu_gnt;
    assign bus.mem_ready = w_mem_gnt;

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!bus.alu_valid || w_alu_gnt) begin
            w_wait_nxt = 4'd0;
        end else if (r_wait_cnt < c_max_wait) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // A write to r0 is still accepted and captured, but never enabled.
    always_comb begin
        w_rf_write_nxt  = 1'b0;
        w_rf_wraddr_nxt = r_rf_wraddr;
        w_rf_wrdata_nxt = r_rf_wrdata;
        if (w_alu_gnt) begin
            w_rf_write_nxt  = |bus.alu_addr;
            w_rf_wraddr_nxt = bus.alu_addr;
            w_rf_wrdata_nxt = bus.alu_data;
        end else if (w_mem_gnt) begin
            w_rf_write_nxt  = |bus.mem_addr;
            w_rf_wraddr_nxt = bus.mem_addr;
            w_rf_wrdata_nxt = bus.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_write  <= 1'b0;
            r_rf_wraddr <= 5'd0;
            r_rf_wrdata <= 32'd0;
        end else begin
            r_rf_write  <= w_rf_write_nxt;
            r_rf_wraddr <= w_rf_wraddr_nxt;
            r_rf_wrdata <= w_rf_wrdata_nxt;
        end
    end

    assign bus.rf_write  = r_rf_write;
    assign bus.rf_wrAddr = r_rf_wraddr;
    assign bus.rf_wrData = r_rf_wrdata;

    // Set beats clear on the same register; bit 0 is masked so r0 never stalls.
    always_comb begin
        w_set         = (bus.load_issue && (bus.load_addr != 5'd0))
                        ? (32'd1 << bus.load_addr) : 32'd0;
        w_clr         = w_mem_gnt ? (32'd1 << bus.mem_addr) : 32'd0;
        w_pending_nxt = ((r_pending & ~w_clr) | w_set) & ~32'd1;
        w_sb_err_nxt  = r_sb_err | (|(w_set & r_pending & ~w_clr));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 32'd0;
            r_sb_err  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_sb_err  <= w_sb_err_nxt;
        end
    end

    assign bus.hazard = r_pending[bus.chk_addr_a] | r_pending[bus.chk_addr_b];
    assign bus.sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_wb_arbiter
// Purpose  : Vector-table bench with a queue of expected register-file writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_wb_arbiter;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        li;
        logic [4:0]  la;
        logic [4:0]  ca;
        logic [4:0]  cb;
        logic        ear;
        logic        emr;
        logic        ehz;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
    } rf_t;

    logic clk;
    logic reset;
    mips_cpu_wb_arbiter_if bus ();

    mips_cpu_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t        vecs[$];
    rf_t         sbq[$];
    int          n_vec = 0;
    int          miscompares = 0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;

    function automatic vec_t mk(input logic rst, input logic av, input logic [4:0] aa,
                                input logic [31:0] ad, input logic mv, input logic [4:0] ma,
                                input logic [31:0] md, input logic li, input logic [4:0] la,
                                input logic [4:0] ca, input logic [4:0] cb, input logic ear,
                                input logic emr, input logic ehz, input logic eerr);
        vec_t v;
        v.rst = rst; v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv;   v.ma = ma; v.md = md; v.li = li; v.la = la;
        v.ca = ca;   v.cb = cb;
        v.ear = ear; v.emr = emr; v.ehz = ehz; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", nm, n_vec, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        rf_t e;
        @(posedge clk);
        #1;
        reset          = v.rst;
        bus.alu_valid  = v.av;  bus.alu_addr  = v.aa; bus.alu_data = v.ad;
        bus.mem_valid  = v.mv;  bus.mem_addr  = v.ma; bus.mem_data = v.md;
        bus.load_issue = v.li;  bus.load_addr = v.la;
        bus.chk_addr_a = v.ca;  bus.chk_addr_b = v.cb;
        @(negedge clk);
        check("alu_ready", 32'(bus.alu_ready), 32'(v.ear));
        check("mem_ready", 32'(bus.mem_ready), 32'(v.emr));
        check("hazard",    32'(bus.hazard),    32'(v.ehz));
        check("sb_err",    32'(bus.sb_err),    32'(v.eerr));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("rf_write",  32'(bus.rf_write),  32'(e.w));
            check("rf_wrAddr", 32'(bus.rf_wrAddr), 32'(e.a));
            check("rf_wrData", bus.rf_wrData,      e.d);
        end
        // Expected write-port state after the coming edge, from the expected grant.
        if (v.rst) begin
            m_addr = 5'd0; m_data = 32'd0;
            e.w = 1'b0;
        end else if (v.ear) begin
            m_addr = v.aa; m_data = v.ad;
            e.w = (v.aa != 5'd0);
        end else if (v.emr) begin
            m_addr = v.ma; m_data = v.md;
            e.w = (v.ma != 5'd0);
        end else begin
            e.w = 1'b0;
        end
        e.a = m_addr;
        e.d = m_data;
        sbq.push_back(e);
        n_vec++;
    endtask

    function automatic vec_t both(input logic [4:0] ca, input logic [4:0] cb,
                                  input logic ear, input logic emr, input logic ehz);
        return mk(0, 1, 5'd6, 32'h1111_1111, 1, 5'd15, 32'h2222_2222, 0, 0, ca, cb,
                  ear, emr, ehz, 0);
    endfunction

    initial begin
        reset = 1'b1;
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
        bus.load_issue = 0; bus.load_addr = 0;
        bus.chk_addr_a = 0; bus.chk_addr_b = 0;
        repeat (2) @(posedge clk);

        //                rst av aa  ad             mv ma  md            li la  ca  cb  ar mr hz er
        vecs.push_back(mk(1, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5,  32'hDEADBEEF,  0, 0,  32'h0,        0, 0,  0,  0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0,  0,  0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 6, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 6,  32'h11111111,  1, 7,  32'h22222222, 0, 0,  0,  0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 6,  32'h11111111,  1, 7,  32'h22222222, 0, 0,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        1, 8,  8,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  8,  0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         1, 8,  32'hCAFE0008, 0, 0,  8,  0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  8,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        1, 9,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  1,  9,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         1, 9,  32'hCAFE0009, 0, 0,  0,  9,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0,  9,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        1, 0,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  32'h12345678,  0, 0,  32'h0,        0, 0,  0,  0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        1, 3,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        1, 3,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  3,  0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,         1, 3,  32'h00000033, 1, 3,  3,  0,  0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 6,  32'h00000001,  1, 7,  32'h00000002, 0, 0,  3,  0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  3,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        1, 3,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         1, 3,  32'h00000044, 1, 3,  3,  0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  3,  0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        1, 10, 0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,         0, 0,  32'h0,        1, 11, 0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 6,  32'hAAAA0001,  1, 15, 32'hBBBB0001, 1, 12, 0,  0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 6,  32'hAAAA0002,  1, 15, 32'hBBBB0002, 1, 13, 0,  0,  0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 6,  32'hAAAA0003,  1, 15, 32'hBBBB0003, 0, 0,  10, 13, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 6,  32'hAAAA0004,  1, 15, 32'hBBBB0004, 0, 0,  10, 13, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 6, 32'hAAAA0005, 1, 15, 32'hBBBB0005, 0, 0, 11, 12, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 6,  32'hAAAA0006,  1, 15, 32'hBBBB0006, 0, 0,  0,  0,  1, 0, 0, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Starvation count must restart when the ALU drops its request.
        step(both(0, 0, 0, 1, 0));
        step(both(0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 32'h0, 1, 5'd15, 32'h2222_3333, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) step(both(0, 0, 0, 1, 0));
        step(both(0, 0, 1, 0, 0));

        // Fill a few pending bits including r31, then reset and sweep every address.
        step(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 5'd1,  0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 5'd17, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 5'd20, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 5'd31, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 5'd31, 5'd2, 0, 0, 1, 0));
        step(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 5'd17, 5'd0, 0, 0, 1, 0));
        for (int a = 0; a < 32; a++)
            step(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 5'(a), 5'(31 - a), 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
